// File: rtl/step_pulse_gen.sv
// step_pulse_gen: turns clock-enable ticks into a counted STEP/DIR pulse train with busy/done/abort status.
module step_pulse_gen #(
  parameter int STEP_CNT_W      = 16,
  parameter int DIR_SETUP_TICKS = 2
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic                  i_clk_en,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_dir,
  input  logic [STEP_CNT_W-1:0] i_step_count,
  output logic                  o_step,
  output logic                  o_dir,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_aborted,
  output logic [STEP_CNT_W-1:0] o_steps_remaining
);
  localparam int SW = (DIR_SETUP_TICKS > 1) ? $clog2(DIR_SETUP_TICKS) : 1;
  typedef enum logic [2:0] {IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW, DONE} state_t;
  state_t state, state_n;
  logic start_q, armed, start_edge;
  logic step_n, dir_n, aborted_n;
  logic [SW-1:0] setup_cnt, setup_n;
  logic [STEP_CNT_W-1:0] rem_n;
  // armed masks the first clock after reset so a start held through reset is not seen as an edge
  assign start_edge = i_start & ~start_q & armed;
  assign o_busy = (state == DIR_SETUP) || (state == STEP_HIGH) || (state == STEP_LOW);
  assign o_done = state == DONE;
  always_comb begin
    state_n   = state;
    setup_n   = setup_cnt;
    step_n    = o_step;
    dir_n     = o_dir;
    aborted_n = o_aborted;
    rem_n     = o_steps_remaining;
    case (state)
      IDLE: if (start_edge) begin
        dir_n     = i_dir;
        rem_n     = i_step_count;
        aborted_n = 1'b0;
        setup_n   = '0;
        state_n   = (i_step_count == '0) ? DONE : DIR_SETUP;
      end
      DONE: state_n = IDLE;
      default: if (i_abort) begin
        step_n    = 1'b0;
        aborted_n = 1'b1;
        state_n   = DONE;
      end else if (i_clk_en) begin
        case (state)
          DIR_SETUP: if (setup_cnt == SW'(DIR_SETUP_TICKS - 1)) begin
            step_n  = 1'b1;
            state_n = STEP_HIGH;
          end else setup_n = setup_cnt + SW'(1);
          STEP_HIGH: begin
            step_n  = 1'b0;
            rem_n   = o_steps_remaining - STEP_CNT_W'(1);
            state_n = STEP_LOW;
          end
          default: if (o_steps_remaining == '0) state_n = DONE;
          else begin
            step_n  = 1'b1;
            state_n = STEP_HIGH;
          end
        endcase
      end
    endcase
  end
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state             <= IDLE;
      start_q           <= 1'b0;
      armed             <= 1'b0;
      setup_cnt         <= '0;
      o_step            <= 1'b0;
      o_dir             <= 1'b0;
      o_aborted         <= 1'b0;
      o_steps_remaining <= '0;
    end else begin
      state             <= state_n;
      start_q           <= i_start;
      armed             <= 1'b1;
      setup_cnt         <= setup_n;
      o_step            <= step_n;
      o_dir             <= dir_n;
      o_aborted         <= aborted_n;
      o_steps_remaining <= rem_n;
    end
  end
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: directed scenarios plus random moves against a tick-count model of the pulse train.
module tb_step_pulse_gen;
  localparam int W = 16, D = 2;
  logic clk = 0, rst = 0, clk_en = 0, start = 0, abort = 0, dir = 0;
  logic [W-1:0] cnt = '0;
  logic step, odir, busy, done, aborted;
  logic [W-1:0] rem;
  int pass_n = 0, total_n = 0;
  int rises, hi, dones, busys, ncyc, first_rise, tick_mode = 0, tctr = 0;
  logic prev_step = 0;
  int m_mode = 0, m_ticks = 0, m_n = 0, m_rem = 0;
  logic m_dir = 0, m_abt = 0, m_sq = 0, m_arm = 0;
  always #5 clk = ~clk;
  step_pulse_gen #(.STEP_CNT_W(W), .DIR_SETUP_TICKS(D)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .i_clk_en(clk_en), .i_start(start),
    .i_abort(abort), .i_dir(dir), .i_step_count(cnt), .o_step(step), .o_dir(odir),
    .o_busy(busy), .o_done(done), .o_aborted(aborted), .o_steps_remaining(rem)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // A move is fully described by N and the number of ticks seen since acceptance
  function automatic int rem_at(input int n, input int t);
    int j = t - D;
    return (j < 0) ? n : n - (j + 1) / 2;
  endfunction
  function automatic bit step_at(input int n, input int t);
    int j = t - D;
    return j >= 0 && j < 2 * n && j % 2 == 0;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_ticks <= 0; m_n <= 0; m_rem <= 0;
      m_dir <= 0; m_abt <= 0; m_sq <= 0; m_arm <= 0;
    end else begin
      m_sq  <= start;
      m_arm <= 1;
      if (m_mode == 0) begin
        if (start && !m_sq && m_arm) begin
          m_dir <= dir; m_n <= int'(cnt); m_ticks <= 0; m_abt <= 0; m_rem <= int'(cnt);
          m_mode <= (cnt == 0) ? 2 : 1;
        end
      end else if (m_mode == 2) m_mode <= 0;
      else if (abort) begin
        m_abt <= 1; m_mode <= 2;
      end else if (clk_en) begin
        m_ticks <= m_ticks + 1;
        m_rem   <= rem_at(m_n, m_ticks + 1);
        if (m_ticks + 1 == D + 2 * m_n) m_mode <= 2;
      end
    end
  end
  always @(negedge clk) begin
    chk("model_step", step, (m_mode == 1) && step_at(m_n, m_ticks));
    chk("model_dir", odir, m_dir);
    chk("model_busy", busy, m_mode == 1);
    chk("model_done", done, m_mode == 2);
    chk("model_aborted", aborted, m_abt);
    chk("model_rem", rem, m_rem);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
    ncyc++;
    if (step && !prev_step) begin
      rises++;
      if (rises == 1) first_rise = ncyc;
    end
    prev_step = step;
    if (step) hi++;
    if (done) dones++;
    if (busy) busys++;
    tctr++;
    clk_en = (tick_mode == 1) ? (tctr % 4 == 0) : (tick_mode == 2) ? ($urandom_range(2) == 0) : 1'b0;
  endtask
  task automatic clr();
    rises = 0; hi = 0; dones = 0; busys = 0; ncyc = 0; first_rise = 0; prev_step = step;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit found;
    // reset with start held high
    start = 1;
    #1 rst = 1;
    #2;
    chk("rst_step", step, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_rem", rem, 0); chk("rst_dir", odir, 0); chk("rst_aborted", aborted, 0);
    repeat (2) cyc();
    rst = 0;
    clr();
    repeat (6) cyc();
    chk("rst_nostart_busy", busys, 0); chk("rst_nostart_done", dones, 0);
    start = 0;
    cyc();
    // N=3, dir=1, tick every 4 clocks
    tick_mode = 1; tctr = 0; clk_en = 0; cnt = 3; dir = 1; start = 1;
    clr();
    for (int i = 0; i < 200 && dones == 0; i++) cyc();
    chk("n3_done_seen", dones, 1);
    chk("n3_first_rise", first_rise, 9);
    chk("n3_rises", rises, 3);
    chk("n3_high_cycles", hi, 12);
    chk("n3_busy_cycles", busys, 32);
    chk("n3_rem", rem, 0); chk("n3_dir", odir, 1); chk("n3_aborted", aborted, 0);
    cyc();
    chk("n3_done_one_cycle", done, 0);
    start = 0;
    cyc();
    // zero-length move
    cnt = 0; start = 1;
    clr();
    cyc();
    chk("n0_done_now", done, 1); chk("n0_busy", busy, 0);
    repeat (4) cyc();
    chk("n0_done_cnt", dones, 1); chk("n0_busy_cnt", busys, 0);
    start = 0;
    cyc();
    // abort on a tick during the second high phase
    cnt = 5; dir = 0; start = 1; tctr = 0; clk_en = 0;
    clr();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc();
      if (rises == 2 && step && clk_en) found = 1;
    end
    chk("ab_reach", found, 1);
    abort = 1;
    cyc();
    abort = 0;
    chk("ab_step", step, 0); chk("ab_rem", rem, 4); chk("ab_done", done, 1); chk("ab_aborted", aborted, 1);
    start = 0;
    repeat (2) cyc();
    // start edges while busy and in DONE are dropped
    cnt = 1; dir = 1; start = 1;
    cyc();
    repeat (3) cyc();
    start = 0; cyc();
    start = 1; cyc();
    start = 0;
    clr();
    for (int i = 0; i < 100 && dones == 0; i++) cyc();
    chk("dr_done_seen", dones, 1);
    start = 1;
    clr();
    repeat (6) cyc();
    chk("dr_busy", busys, 0); chk("dr_done", dones, 0);
    start = 0; cyc();
    dir = 0; start = 1; cyc();
    chk("dr_accept", busy, 1); chk("dr_dir", odir, 0);
    clr();
    for (int i = 0; i < 100 && dones == 0; i++) cyc();
    chk("dr_finish", dones, 1);
    start = 0; cyc();
    // reset mid high phase with N=max
    cnt = 16'hFFFF; start = 1;
    clr();
    for (int i = 0; i < 100 && !step; i++) cyc();
    chk("mx_high", step, 1);
    clr();
    rst = 1;
    #1;
    chk("mx_rst_step", step, 0); chk("mx_rst_rem", rem, 0); chk("mx_rst_busy", busy, 0);
    cyc();
    rst = 0;
    repeat (3) cyc();
    chk("mx_rst_nodone", dones, 0);
    start = 0; cyc();
    start = 1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc();
      if (rem == 16'hFFFD && !step && busy) found = 1;
    end
    chk("mx_reach", found, 1);
    abort = 1; cyc(); abort = 0;
    chk("mx_ab_rem", rem, 16'hFFFD); chk("mx_ab_aborted", aborted, 1); chk("mx_ab_done", done, 1);
    start = 0; cyc();
    // random moves
    tick_mode = 2;
    for (int i = 0; i < 2500; i++) begin
      cyc();
      if ($urandom_range(5) == 0) start = ~start;
      dir   = 1'($urandom_range(1));
      cnt   = W'($urandom_range(6));
      abort = ($urandom_range(60) == 0);
    end
    abort = 0; start = 0;
    repeat (3) cyc();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
